muldiv_unit: RTL

Iterative unsigned multiply/divide unit that sits beside the ALU in the execute stage. It takes the same operand buses (I1, I2) and hands its result to the writeback result mux downstream of the ALU. It implements MUL, MULHU, DIVU and REMU over W cycles with a start/busy/done handshake. The control unit holds the pipeline while busy is high.

---
 rtl/muldiv_unit_if.sv | 24 ++
 rtl/muldiv_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake and operand/result bundle between the execute-stage control and muldiv_unit.
// The unit connects through the slave modport; the issuing side uses master.
interface muldiv_unit_if #(
  parameter int W = 32
);
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] I1;
  logic [W-1:0] I2;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic         dz_flag;

  modport master (
    output start, op, I1, I2,
    input  busy, done, out, dz_flag
  );

  modport slave (
    input  start, op, I1, I2,
    output busy, done, out, dz_flag
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: shift-add MUL/MULHU, restoring DIVU/REMU.
// Each operation takes W iterations; result and divide-by-zero flag are held until the next accept.
module muldiv_unit #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  muldiv_unit_if.slave   bus
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_nx;
  logic [CW-1:0]  cnt_q;
  logic [2*W:0]   acc_q, acc_nx;
  logic [W-1:0]   a_q, b_q;
  logic [1:0]     op_q;
  logic [W-1:0]   out_q;
  logic           dz_q;
  logic           done_q;

  logic           accept;
  logic           div_zero;
  logic           last_iter;
  logic [W:0]     rem_sh;
  logic [W:0]     sum;
  logic           ge;

  // Both layouts put the low result (product low / quotient) in acc[W-1:0]
  // and the high result (product high / remainder) in acc[2W-1:W].
  function automatic logic [W-1:0] sel_result(input logic [1:0] op, input logic [2*W-1:0] acc);
    return op[0] ? acc[2*W-1:W] : acc[W-1:0];
  endfunction

  function automatic logic [W-1:0] dz_result(input logic [1:0] op, input logic [W-1:0] dividend);
    return op[0] ? dividend : {W{1'b1}};
  endfunction

  assign accept    = (state_q == IDLE) && bus.start;
  assign div_zero  = accept && bus.op[1] && (bus.I2 == '0);
  assign last_iter = (state_q == RUN) && (cnt_q == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_nx = div_zero ? DONE : RUN;
      end
      RUN: begin
        if (last_iter) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One iteration of the selected algorithm, applied to the current accumulator
  always_comb begin
    acc_nx = acc_q;
    rem_sh = '0;
    sum    = '0;
    ge     = 1'b0;
    if (op_q[1]) begin
      rem_sh          = {acc_q[2*W-1:W], a_q[W-1]};
      ge              = (rem_sh >= {1'b0, b_q});
      acc_nx[2*W:W]   = ge ? (rem_sh - {1'b0, b_q}) : rem_sh;
      acc_nx[W-1:0]   = {acc_q[W-2:0], ge};
    end else begin
      sum    = acc_q[2*W:W] + (b_q[0] ? {1'b0, a_q} : '0);
      acc_nx = {sum, acc_q[W-1:0]} >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      out_q  <= '0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        cnt_q <= '0;
        acc_q <= '0;
        if (div_zero) begin
          out_q  <= dz_result(bus.op, bus.I1);
          dz_q   <= 1'b1;
          done_q <= 1'b1;
        end
      end else if (state_q == RUN) begin
        acc_q <= acc_nx;
        cnt_q <= cnt_q + 1'b1;
        if (last_iter) begin
          out_q  <= sel_result(op_q, acc_nx[2*W-1:0]);
          dz_q   <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  // Operand registers: dividend shifts out MSB-first, multiplier LSB-first
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= bus.I1;
      b_q  <= bus.I2;
      op_q <= bus.op;
    end else if (state_q == RUN) begin
      if (op_q[1]) a_q <= a_q << 1;
      else         b_q <= b_q >> 1;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.out     = out_q;
  assign bus.dz_flag = dz_q;

endmodule
